// File: rtl/dp_types_pkg.sv
// Shared datapath types for the branch predictor: BTB entry layout, counter constants, update bundle.
package dp_types_pkg;

    localparam int unsigned DP_WORD_W   = 32;
    localparam int unsigned DP_ENTRIES  = 16;
    localparam int unsigned DP_CTR_BITS = 2;
    localparam int unsigned DP_IDX_W    = $clog2(DP_ENTRIES);
    localparam int unsigned DP_TAG_W    = DP_WORD_W - DP_IDX_W - 2;

    localparam logic [DP_CTR_BITS-1:0] CTR_WNT = 2'b01;
    localparam logic [DP_CTR_BITS-1:0] CTR_WT  = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [DP_TAG_W-1:0]   tag;
        logic [DP_WORD_W-1:0]  target;
    } btb_entry_t;

    typedef struct packed {
        logic                  en;
        logic [DP_WORD_W-1:0]  pc;
        logic                  taken;
        logic [DP_WORD_W-1:0]  target;
    } bp_req_t;

endpackage

// File: rtl/branch_pred_if.sv
// Fetch-side lookup and execute-side update bundle between the pipeline and the predictor.
interface branch_pred_if;
    import dp_types_pkg::*;

    logic [DP_WORD_W-1:0] cpc;
    logic [DP_WORD_W-1:0] pc4;
    logic                 phit;
    logic                 ptaken;
    logic [DP_WORD_W-1:0] npc;
    bp_req_t              req;

    modport bp (input cpc, input req, output pc4, output phit, output ptaken, output npc);
    modport tb (output cpc, output req, input pc4, input phit, input ptaken, input npc);
endinterface

// File: rtl/sat_counter_table.sv
// ENTRIES x CTR_BITS saturating counter table with one combinational read and one registered update.
module sat_counter_table #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned IDX_W    = $clog2(ENTRIES)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                upd_en,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic                upd_taken
);
    // Weakly not-taken: 2^(CTR_BITS-1)-1, which is 0 for a 1-bit counter.
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] ctr [ENTRIES];

    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr[i] <= CTR_RST;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (ctr[upd_idx] != '1) ctr[upd_idx] <= ctr[upd_idx] + CTR_BITS'(1);
            end else begin
                if (ctr[upd_idx] != '0) ctr[upd_idx] <= ctr[upd_idx] - CTR_BITS'(1);
            end
        end
    end
endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped tagged BTB plus saturating-counter PHT with same-cycle lookup.
// Optional gshare PHT indexing enabled by defining BP_GSHARE_EN.
module branch_predictor_btb
    import dp_types_pkg::*;
#(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] cpc,
    output logic [WORD_W-1:0] pc4,
    output logic              phit,
    output logic              ptaken,
    output logic [WORD_W-1:0] npc,
    input  logic              upd_en,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [WORD_W-1:0] upd_target
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

    logic [ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]   btb_tag    [ENTRIES];
    logic [WORD_W-1:0]  btb_target [ENTRIES];

    logic [IDX_W-1:0]    rd_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic [IDX_W-1:0]    up_idx;
    logic [TAG_W-1:0]    up_tag;
    logic [IDX_W-1:0]    rd_pidx;
    logic [IDX_W-1:0]    up_pidx;
    logic [CTR_BITS-1:0] rd_ctr;

    assign rd_idx = cpc[IDX_W+1:2];
    assign rd_tag = cpc[WORD_W-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[WORD_W-1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Concatenate-then-truncate keeps the shift legal when IDX_W is 1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ghr <= '0;
        else if (upd_en) ghr <= IDX_W'({ghr, upd_taken});
    end

    assign rd_pidx = rd_idx ^ ghr;
    assign up_pidx = up_idx ^ ghr;
`else
    assign rd_pidx = rd_idx;
    assign up_pidx = up_idx;
`endif

    sat_counter_table #(
        .ENTRIES  (ENTRIES),
        .CTR_BITS (CTR_BITS),
        .IDX_W    (IDX_W)
    ) u_pht (
        .CLK       (CLK),
        .RST       (RST),
        .rd_idx    (rd_pidx),
        .rd_ctr    (rd_ctr),
        .upd_en    (upd_en),
        .upd_idx   (up_pidx),
        .upd_taken (upd_taken)
    );

    // Taken branches allocate on miss and retarget on hit; both reduce to the same write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btb_valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (upd_en && upd_taken) begin
            btb_valid[up_idx]  <= 1'b1;
            btb_tag[up_idx]    <= up_tag;
            btb_target[up_idx] <= upd_target;
        end
    end

    assign pc4    = cpc + WORD_W'(4);
    assign phit   = !RST && btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign ptaken = phit && rd_ctr[CTR_BITS-1];
    assign npc    = ptaken ? btb_target[rd_idx] : pc4;

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised dynamic branch predictor for the pipelined datapath. Replaces the static pc4/baddr select.
- Fetch stage presents cpc. The block returns a same-cycle prediction: BTB hit, taken/not-taken, next PC.
- Resolved branches from the execute/memory stage train a tagged branch target buffer (BTB) and an untagged table of saturating counters (PHT).

Parameters:
- WORD_W, 32, PC/target width.
- ENTRIES, 16, BTB and PHT depth; power of two, >= 2.
- CTR_BITS, 2, saturating counter width; >= 1.
- IDX_W (localparam), $clog2(ENTRIES), index width.
- TAG_W (localparam), WORD_W-IDX_W-2, tag width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- cpc  in  WORD_W  current fetch PC.
- pc4  out  WORD_W  cpc+4.
- phit  out  1  BTB hit for cpc.
- ptaken  out  1  predicted taken.
- npc  out  WORD_W  predicted next fetch PC.
- upd_en  in  1  a branch resolved this cycle.
- upd_pc  in  WORD_W  PC of the resolved branch.
- upd_taken  in  1  actual branch direction.
- upd_target  in  WORD_W  actual branch target.

Behaviour:
- Addressing:
  - Index = pc[IDX_W+1:2]; tag = pc[WORD_W-1:IDX_W+2]; pc[1:0] ignored.
  - BTB entry = {valid, tag[TAG_W], target[WORD_W]}; PHT entry = CTR_BITS counter.
- Lookup is purely combinational (0-cycle latency):
  - phit = btb[idx].valid && btb[idx].tag==tag(cpc).
  - ptaken = phit && pht[pidx][CTR_BITS-1].
  - npc = ptaken ? btb[idx].target : pc4.
  - pc4 = cpc+4, modulo 2^WORD_W (wraps 0xFFFFFFFC -> 0x0).
- Update is registered and takes effect at the CLK edge where upd_en=1:
  - PHT: pht[upd pidx] saturating +1 if upd_taken, -1 otherwise; clamps at all-ones / zero. Updated on every upd_en, whether or not the BTB hits.
  - BTB hit, upd_taken=1: target overwritten with upd_target.
  - BTB hit, upd_taken=0: entry unchanged.
  - BTB miss, upd_taken=1: allocate (direct-mapped overwrite); valid=1, tag, target.
  - BTB miss, upd_taken=0: no allocation.
- Simultaneous lookup and update on the same entry: lookup shows pre-update contents that cycle; the new value is visible the next cycle. No write-through bypass.
- Reset (async assert, any time including mid-update):
  - All BTB valid=0; all PHT counters = weakly not-taken (0b01 for CTR_BITS=2, i.e. 2^(CTR_BITS-1)-1; 0 for CTR_BITS=1); GHR=0.
  - While RST=1: phit=0, ptaken=0, npc=pc4.
  - A pending update is dropped.
- No stall input: the pipeline gates upd_en itself. Exactly one update per cycle.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - IDX_W-bit global history register (GHR). On each upd_en edge: GHR <= {GHR[IDX_W-2:0], upd_taken}; IDX_W=1 loads upd_taken.
  - PHT index pidx = idx XOR GHR for both lookup and update, using the GHR value before the shift.
  - The BTB still uses the plain PC index.
- Undefined: no GHR; pidx = idx.

Decomposition:
- Shared package dp_types_pkg gains:
  - btb_entry_t struct (widths driven by the default parameters).
  - CTR_WNT/CTR_WT default constants.
  - A bp_req_t update bundle.
- Interface branch_pred_if is extended with these ports (modports bp, tb).
- One sub-module: sat_counter_table (ENTRIES x CTR_BITS, read index, update index, direction), instantiated once for the PHT.

Test Plan:
- Reset, cpc=0x00000040 -> phit=0, ptaken=0, npc=pc4=0x00000044. Repeat with RST pulsed mid-training -> same values, no prior entries hit.
- upd_en, pc=0x40, taken, target=0x100; next cycle cpc=0x40 -> phit=1, ctr=0b10, ptaken=1, npc=0x100.
- Two not-taken updates on 0x40 -> ctr 10->01->00; phit=1, ptaken=0, npc=0x44. Four taken updates -> ctr 11; one not-taken -> 10, still npc=0x100.
- Alias test, ENTRIES=16: 0x40 trained taken to 0x100, then 0x440 taken to 0x200 -> cpc=0x440 npc=0x200; cpc=0x40 phit=0, npc=0x44.
- Same-cycle update and lookup on 0x80 -> that cycle phit=0; next cycle phit=1. cpc=0xFFFFFFFC with no hit -> npc=0x00000000.
- BP_GSHARE_EN: branch 0x40 alternates T/N for 8 resolutions -> after warm-up, predictions match the actual direction each time. Without the macro -> mispredicts persist.
